aes128_encrypter: RTL and testbench



---
 rtl/aes_pkg.sv | 175 +++++++++++++++++
 rtl/aes_key_step.sv | 70 +++++++
 rtl/aes128_encrypter.sv | 157 +++++++++++++++
 tb/tb_aes128_encrypter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants and byte/state helpers for the iterative AES-128 core.
//   - FSM state enum for aes128_encrypter
//   - forward S-box (and inverse S-box when DECRYPT_EN is defined)
//   - Rcon lookup, xtime and GF(2^8) multiply (poly x^8+x^4+x^3+x+1)
//   - whole-state round transforms (SubBytes, ShiftRows, MixColumns and,
//     with DECRYPT_EN, their inverses)
// State byte i lives at bits [127-8i -: 8]; byte i is row i%4, column i/4.
// Build option: define DECRYPT_EN to compile in the inverse-cipher helpers.
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KEXP  = 2'd1,
        ST_ROUND = 2'd2,
        ST_FINAL = 2'd3
    } aes_state_e;

    // Byte b of the table sits at bits [2047-8b -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // 2047 - 8*b == {~b, 3'b111}, which keeps the index a plain bit pattern.
    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = sub_byte(s[127-8*i -: 8]);
        return o;
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

`ifdef DECRYPT_EN
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv_sub_byte(s[127-8*i -: 8]);
        return o;
    endfunction

    // Row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction
`endif

endpackage

// File: rtl/aes_key_step.sv
// -----------------------------------------------------------------------------
// aes_key_step
// Combinational single AES-128 round-key step.
//   key      in  128  current round key (words w0..w3, w0 in [127:96])
//   rcon     in  8    round constant of the step being taken (or undone)
//   dir      in  1    0 = forward (rk[i] -> rk[i+1]), 1 = inverse (rk[i] -> rk[i-1])
//   next_key out 128  resulting round key
// Build option: DECRYPT_EN compiles in the inverse direction; without it
// dir is ignored and only the forward step exists.
// -----------------------------------------------------------------------------
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key,
    input  logic [7:0]   rcon,
    input  logic         dir,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] g_in;
    logic [31:0] g_out;

    assign w0 = key[127:96];
    assign w1 = key[95:64];
    assign w2 = key[63:32];
    assign w3 = key[31:0];

    // Both directions need SubWord(RotWord(previous w3)) once. Going
    // backwards, the previous w3 is recovered as w3 ^ w2, so one shared
    // SubWord serves both directions.
`ifdef DECRYPT_EN
    assign g_in = dir ? (w3 ^ w2) : w3;
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign g_in       = w3;
`endif

    always_comb begin
        g_out = '0;
        g_out[31:24] = sub_byte(g_in[23:16]) ^ rcon;
        g_out[23:16] = sub_byte(g_in[15:8]);
        g_out[15:8]  = sub_byte(g_in[7:0]);
        g_out[7:0]   = sub_byte(g_in[31:24]);
    end

    always_comb begin
        next_key = '0;
`ifdef DECRYPT_EN
        if (dir) begin
            next_key[31:0]   = w3 ^ w2;
            next_key[63:32]  = w2 ^ w1;
            next_key[95:64]  = w1 ^ w0;
            next_key[127:96] = w0 ^ g_out;
        end else begin
            next_key[127:96] = w0 ^ g_out;
            next_key[95:64]  = w1 ^ w0 ^ g_out;
            next_key[63:32]  = w2 ^ w1 ^ w0 ^ g_out;
            next_key[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ g_out;
        end
`else
        next_key[127:96] = w0 ^ g_out;
        next_key[95:64]  = w1 ^ w0 ^ g_out;
        next_key[63:32]  = w2 ^ w1 ^ w0 ^ g_out;
        next_key[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ g_out;
`endif
    end

endmodule

// File: rtl/aes128_encrypter.sv
// -----------------------------------------------------------------------------
// aes128_encrypter
// Iterative AES-128 core, one round per clock, round keys generated on the fly.
//   clk      in  1    system clock
//   reset    in  1    asynchronous, active-high reset
//   start    in  1    request; accepted in IDLE (busy=0)
//   decrypt  in  1    1 = inverse cipher, captured with start
//   data_in  in  128  input block, byte 0 in [127:120]
//   key_in   in  128  cipher key, same byte order
//   data_out out 128  result, held until the next result is loaded
//   busy     out 1    operation in progress
//   done     out 1    one-cycle pulse when data_out is updated
// Handshake: start is taken on any rising edge where start=1 and busy=0; the
// result appears 10 edges later (20 for decrypt) together with a one-cycle
// done and busy low, so a new start may be presented in the done cycle.
// Build option: DECRYPT_EN adds the inverse cipher and the KEXP state;
// without it decrypt is ignored and every request is an encryption.
// Observation point: fsm_state holds the current FSM state.
// -----------------------------------------------------------------------------
module aes128_encrypter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         decrypt,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic [127:0] data_out,
    output logic         busy,
    output logic         done
);

    aes_state_e   fsm_state;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [3:0]   rnd;          // round number whose key is produced next
    logic [127:0] next_key;
    logic         key_dir;
    logic [127:0] fwd_round;
    logic [127:0] fwd_final;

`ifdef DECRYPT_EN
    logic         dec_reg;
    logic [127:0] inv_round;
    logic [127:0] inv_final;

    // KEXP walks the key forward; every later decrypt step walks it back.
    assign key_dir   = dec_reg && (fsm_state != ST_KEXP);
    assign inv_round = inv_mix_columns(inv_sub_bytes(inv_shift_rows(state_reg)) ^ next_key);
    assign inv_final = inv_sub_bytes(inv_shift_rows(state_reg)) ^ next_key;
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt;
    assign key_dir        = 1'b0;
`endif

    assign fwd_round = mix_columns(shift_rows(sub_bytes(state_reg))) ^ next_key;
    assign fwd_final = shift_rows(sub_bytes(state_reg)) ^ next_key;

    // rnd-1 selects the Rcon that links rk[rnd-1] and rk[rnd] in both
    // directions: forward it builds rk[rnd], backward it recovers rk[rnd-1].
    aes_key_step u_key_step (
        .key      (key_reg),
        .rcon     (rcon(rnd - 4'd1)),
        .dir      (key_dir),
        .next_key (next_key)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_state <= ST_IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            rnd       <= '0;
            data_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DECRYPT_EN
            dec_reg   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (fsm_state)
                ST_IDLE: begin
                    if (start) begin
                        key_reg <= key_in;
                        rnd     <= 4'd1;
                        busy    <= 1'b1;
`ifdef DECRYPT_EN
                        dec_reg <= decrypt;
                        if (decrypt) begin
                            state_reg <= data_in;
                            fsm_state <= ST_KEXP;
                        end else begin
                            state_reg <= data_in ^ key_in;
                            fsm_state <= ST_ROUND;
                        end
`else
                        state_reg <= data_in ^ key_in;
                        fsm_state <= ST_ROUND;
`endif
                    end
                end

`ifdef DECRYPT_EN
                ST_KEXP: begin
                    key_reg <= next_key;
                    if (rnd == 4'd10) begin
                        // rnd stays at 10: the first inverse step undoes step 10.
                        state_reg <= state_reg ^ next_key;
                        fsm_state <= ST_ROUND;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
`endif

                ST_ROUND: begin
                    key_reg <= next_key;
`ifdef DECRYPT_EN
                    if (dec_reg) begin
                        state_reg <= inv_round;
                        rnd       <= rnd - 4'd1;
                        if (rnd == 4'd2) fsm_state <= ST_FINAL;
                    end else begin
                        state_reg <= fwd_round;
                        rnd       <= rnd + 4'd1;
                        if (rnd == 4'd9) fsm_state <= ST_FINAL;
                    end
`else
                    state_reg <= fwd_round;
                    rnd       <= rnd + 4'd1;
                    if (rnd == 4'd9) fsm_state <= ST_FINAL;
`endif
                end

                ST_FINAL: begin
`ifdef DECRYPT_EN
                    data_out <= dec_reg ? inv_final : fwd_final;
`else
                    data_out <= fwd_final;
`endif
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    fsm_state <= ST_IDLE;
                end

                default: begin
                    fsm_state <= ST_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_encrypter.sv
// -----------------------------------------------------------------------------
// tb_aes128_encrypter
// Directed-vector bench for aes128_encrypter. The driver pushes expected
// results, start cycles and latencies into queues; an independent monitor
// pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_aes128_encrypter;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk;
    logic         reset;
    logic         start;
    logic         decrypt;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic [127:0] data_out;
    logic         busy;
    logic         done;

    logic [127:0] exp_q[$];
    int           st_q[$];
    int           lat_q[$];

    int tests     = 0;
    int fails     = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    int exp_dones = 0;

    aes128_encrypter dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .decrypt  (decrypt),
        .data_in  (data_in),
        .key_in   (key_in),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                logic [127:0] e;
                int s;
                int l;
                e = exp_q.pop_front();
                s = st_q.pop_front();
                l = lat_q.pop_front();
                check("result", data_out, e);
                check("latency", 128'(cyc - s), 128'(l));
                check("busy_low_at_done", {127'd0, busy}, 128'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Call at a negedge: presents start for exactly one rising edge, then
    // scrambles the inputs to show they are not used after capture.
    task automatic drive_start(input logic [127:0] d, input logic [127:0] k, input logic dec,
                               input bit push, input logic [127:0] e, input int lat);
        data_in = d;
        key_in  = k;
        decrypt = dec;
        start   = 1'b1;
        if (push) begin
            exp_q.push_back(e);
            st_q.push_back(cyc + 1);
            lat_q.push_back(lat);
            exp_dones++;
        end
        @(negedge clk);
        start   = 1'b0;
        data_in = {$urandom, $urandom, $urandom, $urandom};
        key_in  = {$urandom, $urandom, $urandom, $urandom};
        decrypt = 1'($urandom_range(0, 1));
        check("busy_after_start", {127'd0, busy}, 128'd1);
    endtask

    task automatic issue(input logic [127:0] d, input logic [127:0] k, input logic dec,
                         input bit push, input logic [127:0] e, input int lat);
        @(negedge clk);
        drive_start(d, k, dec, push, e, lat);
    endtask

    // Returns at the negedge on which done is high.
    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done within %0d cycles expected done", budget);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        decrypt = 1'b0;
        data_in = '0;
        key_in  = '0;
        idle_cycles(3);
        check("reset_data_out", data_out, 128'd0);
        check("reset_busy", {127'd0, busy}, 128'd0);
        check("reset_done", {127'd0, done}, 128'd0);
        reset = 1'b0;

        // Known-answer encryptions.
        issue(P1, K1, 1'b0, 1'b1, C1, 10);
        wait_done(40);
        issue(P2, K2, 1'b0, 1'b1, C2, 10);
        wait_done(40);
        issue(128'd0, 128'd0, 1'b0, 1'b1, CZ, 10);
        wait_done(40);

`ifdef DECRYPT_EN
        issue(C1, K1, 1'b1, 1'b1, P1, 20);
        wait_done(60);
        issue(C2, K2, 1'b1, 1'b1, P2, 20);
        wait_done(60);
`else
        // Without the inverse cipher the decrypt request is an encryption.
        issue(P1, K1, 1'b1, 1'b1, C1, 10);
        wait_done(40);
`endif

        // start while busy is ignored.
        issue(P2, K2, 1'b0, 1'b1, C2, 10);
        idle_cycles(3);
        drive_start(P1, K1, 1'b0, 1'b0, 128'd0, 0);
        wait_done(40);
        idle_cycles(15);
        check("done_count_after_busy_start", 128'(done_cnt), 128'(exp_dones));
        check("result_held", data_out, C2);

        // Reset in the middle of an encryption.
        issue(P1, K1, 1'b0, 1'b0, 128'd0, 0);
        idle_cycles(4);
        reset = 1'b1;
        #1;
        check("abort_data_out", data_out, 128'd0);
        check("abort_busy", {127'd0, busy}, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(15);
        check("abort_no_done", 128'(done_cnt), 128'(exp_dones));
        issue(P2, K2, 1'b0, 1'b1, C2, 10);
        wait_done(40);

        // Back-to-back: second start in the done cycle.
        issue(P1, K1, 1'b0, 1'b1, C1, 10);
        wait_done(40);
        drive_start(P2, K2, 1'b0, 1'b1, C2, 10);
        check("b2b_hold_early", data_out, C1);
        idle_cycles(7);
        check("b2b_hold_late", data_out, C1);
        wait_done(40);
        idle_cycles(3);

        check("queue_drained", 128'(exp_q.size()), 128'd0);
        check("done_count_final", 128'(done_cnt), 128'(exp_dones));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
